spi_master_core: RTL and testbench
==================================

// Module: spi_master_core
// PURPOSE
//  Single-clock SPI master that runs one framed transaction per enable pulse:
//  command bit, address, then data, all MSB first. Writes shift data out on MOSI;
//  reads capture data from MISO. Sits between a register/bus front end and an
//  external SPI slave.
//  Supports all four CPOL/CPHA modes and a programmable SCK divider.
// PARAMETERS
//  DATA_WIDTH     32  bits in the data phase / width of data and data_read
//  ADDRESS_WIDTH  32  bits in the address phase / width of address
// PORTS
//  clock            in   1   system clock; all logic on rising edge
//  reset_n          in   1   asynchronous, active-low reset
//  data             in   DW  write data, latched at start
//  address          in   AW  target address, latched at start
//  enable           in   1   start request, sampled only while idle
//  rd_we            in   1   1=write, 0=read; latched at start
//  divider          in   16  SCK half-period in clock cycles; 0 is treated as 1
//  clock_phase      in   1   CPHA; latched at start
//  clock_polarity   in   1   CPOL (SCK idle level); latched at start
//  MISO             in   1   serial data from slave
//  SCK              out  1   serial clock
//  data_read        out  DW  last completed read data
//  busy             out  1   high from start until end of transaction
//  SS               out  1   active-low slave select
//  MOSI             out  1   serial data to slave
//  data_read_valid  out  1   one-cycle pulse when data_read is updated
// BEHAVIOUR
//  - Reset (async): FSM=IDLE, SS=1, SCK=0, MOSI=0, busy=0, data_read=0, valid=0.
//  - In IDLE, SCK follows clock_polarity, SS=1, MOSI=0.
//  - FSM states: IDLE -> SETUP -> TRANSFER -> HOLD -> IDLE.
//  - IDLE: enable=1 at a rising edge latches all inputs, including D=max(divider,1).
//    The next cycle has busy=1, SS=0 and FSM=SETUP. Enable is ignored while busy.
//  - Frame length N = 1+ADDRESS_WIDTH+DATA_WIDTH bits, MSB first:
//    rd_we, then address[AW-1:0], then data[DW-1:0] (write) or zeros (read).
//  - SETUP lasts D cycles. SCK stays idle. If CPHA=0, MOSI already holds bit 0.
//  - TRANSFER: SCK toggles every D cycles for 2N edges, then returns to CPOL.
//    CPHA=0: sample MISO on leading edges; drive the next MOSI bit on trailing edges.
//    CPHA=1: drive MOSI on leading edges; sample MISO on trailing edges.
//  - MISO is shifted in only for the DW data-phase bits of a read.
//    During a write, MISO is ignored.
//  - HOLD lasts D cycles with SS=0 and SCK idle.
//    At the end of HOLD: SS=1, busy=0, MOSI=0, FSM=IDLE.
//    For a read, data_read is loaded and data_read_valid=1 for exactly that cycle.
//  - busy is high for exactly (2N+2)*D cycles.
//    A new enable is accepted on the first cycle busy=0.
//  - data_read holds its value across writes and until the next read completes.
//  - Changing divider, mode or data inputs mid-transaction has no effect
//    (values are latched at start).
//  - Reset mid-transaction aborts immediately: SS=1, no valid pulse.
// TESTING
//  1 Reset: reset_n=0 -> SS=1, busy=0, SCK=0, data_read=0. Release, hold enable low
//    -> no SCK activity.
//  2 Write, mode 0, D=2, addr=0x10, data=0xA5A5A5A5: slave receives cmd=1,
//    addr 0x10, data 0xA5A5A5A5. busy lasts 264 cycles, 65 SCK pulses, no valid pulse.
//  3 Read, mode 0, D=2, addr=0x10: slave returns 0xA5A5A5A5 -> data_read=0xA5A5A5A5,
//    single valid pulse on the cycle busy falls.
//  4 Modes 1/2/3 with CPOL=1/CPHA=1 combos, read 0x12345678 -> identical data.
//    SCK idles at CPOL; sample edge per CPHA.
//  5 enable pulsed while busy, and divider=0 -> second request ignored.
//    D=0 runs as D=1 (busy 132 cycles).
//  6 reset_n low mid-frame -> SS=1, busy=0 immediately. Next read completes normally.

Source files
------------

// File: rtl/spi_master_core_if.sv
// Bus-side request/status signals and SPI pins of spi_master_core.
// The core attaches through the slave modport; the requesting side and SPI device use master.
interface spi_master_core_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
);
   logic [DATA_WIDTH-1:0]    data;
   logic [ADDRESS_WIDTH-1:0] address;
   logic                     enable;
   logic                     rd_we;
   logic [15:0]              divider;
   logic                     clock_phase;
   logic                     clock_polarity;
   logic [DATA_WIDTH-1:0]    data_read;
   logic                     busy;
   logic                     data_read_valid;
   logic                     MISO;
   logic                     SCK;
   logic                     SS;
   logic                     MOSI;

   modport master (
      output data, address, enable, rd_we, divider, clock_phase, clock_polarity, MISO,
      input  data_read, busy, data_read_valid, SCK, SS, MOSI
   );

   modport slave (
      input  data, address, enable, rd_we, divider, clock_phase, clock_polarity, MISO,
      output data_read, busy, data_read_valid, SCK, SS, MOSI
   );
endinterface

// File: rtl/spi_master_core.sv
// SPI master: one framed transaction (cmd bit, address, data; MSB first) per enable,
// all four CPOL/CPHA modes, SCK half-period of max(divider,1) clock cycles.
module spi_master_core #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
) (
   input logic              clock,
   input logic              reset_n,
   spi_master_core_if.slave bus
);
   localparam int N  = 1 + ADDRESS_WIDTH + DATA_WIDTH;
   localparam int EW = $clog2(2 * N + 1);
   localparam logic [EW-1:0] LAST_EDGE       = EW'(2 * N - 1);
   localparam logic [EW-1:0] FIRST_DATA_EDGE = EW'(2 * (1 + ADDRESS_WIDTH));

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SETUP    = 2'd1;
   localparam logic [1:0] ST_TRANSFER = 2'd2;
   localparam logic [1:0] ST_HOLD     = 2'd3;

   logic [1:0]            state;
   logic [15:0]           div_q;
   logic [15:0]           cnt;
   logic [EW-1:0]         edge_cnt;
   logic                  cpha_q;
   logic                  we_q;
   logic                  sck_q;
   logic                  ss_q;
   logic                  mosi_q;
   logic                  busy_q;
   logic                  valid_q;
   logic [N-1:0]          tx_q;
   logic [N-1:0]          frame;
   logic [DATA_WIDTH-1:0] rx_q;
   logic [DATA_WIDTH-1:0] data_read_q;
   logic                  period_end;
   logic                  leading;
   logic                  sample_edge;

   assign frame       = {bus.rd_we, bus.address, bus.rd_we ? bus.data : '0};
   assign period_end  = (cnt == div_q - 16'd1);
   // Even edge indices are leading edges; CPHA flips which of the pair samples.
   assign leading     = ~edge_cnt[0];
   assign sample_edge = leading ^ cpha_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         div_q       <= 16'd1;
         cnt         <= '0;
         edge_cnt    <= '0;
         cpha_q      <= 1'b0;
         we_q        <= 1'b0;
         sck_q       <= 1'b0;
         ss_q        <= 1'b1;
         mosi_q      <= 1'b0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         tx_q        <= '0;
         rx_q        <= '0;
         data_read_q <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               sck_q  <= bus.clock_polarity;
               ss_q   <= 1'b1;
               mosi_q <= 1'b0;
               if (bus.enable) begin
                  div_q    <= (bus.divider == 16'd0) ? 16'd1 : bus.divider;
                  cpha_q   <= bus.clock_phase;
                  we_q     <= bus.rd_we;
                  cnt      <= '0;
                  edge_cnt <= '0;
                  rx_q     <= '0;
                  busy_q   <= 1'b1;
                  ss_q     <= 1'b0;
                  state    <= ST_SETUP;
                  // CPHA=0 presents the first bit before the first edge.
                  if (!bus.clock_phase) begin
                     mosi_q <= frame[N-1];
                     tx_q   <= frame << 1;
                  end else begin
                     tx_q   <= frame;
                  end
               end
            end
            ST_SETUP: begin
               if (period_end) begin
                  cnt   <= '0;
                  state <= ST_TRANSFER;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_TRANSFER: begin
               if (period_end) begin
                  cnt      <= '0;
                  sck_q    <= ~sck_q;
                  edge_cnt <= edge_cnt + 1'b1;
                  if (sample_edge) begin
                     if (!we_q && edge_cnt >= FIRST_DATA_EDGE)
                        rx_q <= {rx_q[DATA_WIDTH-2:0], bus.MISO};
                  end else begin
                     mosi_q <= tx_q[N-1];
                     tx_q   <= tx_q << 1;
                  end
                  if (edge_cnt == LAST_EDGE)
                     state <= ST_HOLD;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_HOLD: begin
               if (period_end) begin
                  cnt    <= '0;
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
                  ss_q   <= 1'b1;
                  mosi_q <= 1'b0;
                  if (!we_q) begin
                     data_read_q <= rx_q;
                     valid_q     <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.SCK             = sck_q;
   assign bus.SS              = ss_q;
   assign bus.MOSI            = mosi_q;
   assign bus.busy            = busy_q;
   assign bus.data_read       = data_read_q;
   assign bus.data_read_valid = valid_q;
endmodule

// File: tb/tb_spi_master_core.sv
// Randomized bench for spi_master_core: a behavioural SPI slave records the frame on
// MOSI and serves MISO per mode; frame, timing and read data come from the transaction rules.
module tb_spi_master_core;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int N  = 1 + AW + DW;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   spi_master_core_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();
   spi_master_core #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_total = 0;
   int n_bad   = 0;
   logic [DW-1:0] exp_dr = '0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Behavioural SPI slave: bit-level view of the wire, mode chosen by the bench.
   logic         s_cpol = 1'b0;
   logic         s_cpha = 1'b0;
   logic [N-1:0] s_tx_word = '0;
   logic [N-1:0] s_rx = '0;
   int           s_nrx = 0;
   int           s_ntx = 0;
   int           s_pulses = 0;
   logic         prev_ss = 1'b1;
   logic         prev_sck = 1'b0;

   always @(bus.SS or bus.SCK) begin
      if (prev_ss === 1'b1 && bus.SS === 1'b0) begin
         s_rx = '0;
         s_nrx = 0;
         s_ntx = 0;
         s_pulses = 0;
         if (!s_cpha) begin
            bus.MISO = s_tx_word[N-1];
            s_ntx = 1;
         end
      end else if (bus.SS === 1'b0 && bus.SCK !== prev_sck) begin
         if (bus.SCK !== s_cpol) s_pulses++;
         if ((bus.SCK !== s_cpol) == !s_cpha) begin
            s_rx = {s_rx[N-2:0], bus.MOSI};
            s_nrx++;
         end else begin
            if (s_ntx < N) bus.MISO = s_tx_word[N-1-s_ntx];
            s_ntx++;
         end
      end
      prev_ss = bus.SS;
      prev_sck = bus.SCK;
   end

   task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] dat,
                          input logic [15:0] div, input logic cpol, input logic cpha,
                          input logic [DW-1:0] resp, input int poke_at, input int abort_at);
      int d;
      int cyc;
      int exp_cyc;
      int valid_busy;
      logic valid_fall;
      logic [AW:0] junk;
      logic [N-1:0] exp_frame;
      d = (div == 16'd0) ? 1 : int'(div);
      exp_cyc = (2 * N + 2) * d;
      exp_frame = {we, addr, we ? dat : '0};
      junk[AW-1:0] = $urandom;
      junk[AW] = 1'($urandom);
      s_cpol = cpol;
      s_cpha = cpha;
      s_tx_word = {junk, resp};

      bus.rd_we = we;
      bus.address = addr;
      bus.data = dat;
      bus.divider = div;
      bus.clock_phase = cpha;
      bus.clock_polarity = cpol;
      // Let SCK settle at the new idle level before SS falls.
      if (bus.SCK !== cpol) begin
         @(posedge clock); #1;
      end
      bus.enable = 1'b1;
      @(posedge clock); #1;
      bus.enable = 1'b0;
      bus.rd_we = 1'($urandom);
      bus.address = $urandom;
      bus.data = $urandom;
      bus.divider = 16'($urandom_range(7, 0));
      bus.clock_phase = 1'($urandom);
      bus.clock_polarity = 1'($urandom);
      check_val("start_busy", 128'(bus.busy), 128'(1));
      check_val("start_ss", 128'(bus.SS), 128'(0));

      cyc = 1;
      valid_busy = 0;
      valid_fall = 1'b0;
      while (1) begin
         if (cyc == poke_at) bus.enable = 1'b1;
         if (abort_at != 0 && cyc == abort_at) begin
            reset_n = 1'b0;
            #1;
            exp_dr = '0;
            check_val("abort_ss", 128'(bus.SS), 128'(1));
            check_val("abort_busy", 128'(bus.busy), 128'(0));
            check_val("abort_valid", 128'(bus.data_read_valid), 128'(0));
            check_val("abort_data_read", 128'(bus.data_read), 128'(exp_dr));
            @(posedge clock); #1;
            reset_n = 1'b1;
            return;
         end
         @(posedge clock); #1;
         bus.enable = 1'b0;
         if (!bus.busy) begin
            valid_fall = bus.data_read_valid;
            break;
         end
         if (bus.data_read_valid) valid_busy++;
         cyc++;
         if (cyc > exp_cyc + 20) begin
            check_val("busy_timeout", 128'(cyc), 128'(exp_cyc));
            return;
         end
      end

      if (!we) exp_dr = resp;
      check_val("busy_cycles", 128'(cyc), 128'(exp_cyc));
      check_val("valid_while_busy", 128'(valid_busy), 128'(0));
      check_val("valid_at_fall", 128'(valid_fall), 128'(!we));
      check_val("data_read", 128'(bus.data_read), 128'(exp_dr));
      check_val("slave_frame", 128'(s_rx), 128'(exp_frame));
      check_val("slave_bits", 128'(s_nrx), 128'(N));
      check_val("sck_pulses", 128'(s_pulses), 128'(N));
      check_val("end_ss", 128'(bus.SS), 128'(1));
      check_val("end_sck_idle", 128'(bus.SCK), 128'(cpol));
      check_val("end_mosi", 128'(bus.MOSI), 128'(0));
      if (poke_at != 0) begin
         @(posedge clock); #1;
         check_val("poke_ignored", 128'(bus.busy), 128'(0));
         check_val("valid_single", 128'(bus.data_read_valid), 128'(0));
      end
   endtask

   initial begin
      int toggles;
      logic prev;
      logic [1:0] m;
      bus.enable = 1'b0;
      bus.data = '0;
      bus.address = '0;
      bus.rd_we = 1'b0;
      bus.divider = 16'd2;
      bus.clock_phase = 1'b0;
      bus.clock_polarity = 1'b0;
      @(posedge clock); #1;
      check_val("rst_ss", 128'(bus.SS), 128'(1));
      check_val("rst_busy", 128'(bus.busy), 128'(0));
      check_val("rst_sck", 128'(bus.SCK), 128'(0));
      check_val("rst_data_read", 128'(bus.data_read), 128'(0));
      check_val("rst_valid", 128'(bus.data_read_valid), 128'(0));
      reset_n = 1'b1;
      toggles = 0;
      prev = bus.SCK;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         if (bus.SCK !== prev) toggles++;
         prev = bus.SCK;
      end
      check_val("idle_sck_toggles", 128'(toggles), 128'(0));
      check_val("idle_ss", 128'(bus.SS), 128'(1));

      run_txn(1'b1, 32'h10, 32'hA5A5A5A5, 16'd2, 1'b0, 1'b0, $urandom, 0, 0);
      run_txn(1'b0, 32'h10, 32'h0, 16'd2, 1'b0, 1'b0, 32'hA5A5A5A5, 0, 0);
      for (int k = 1; k < 4; k++) begin
         m = 2'(k);
         run_txn(1'b0, $urandom, $urandom, 16'd2, m[1], m[0], 32'h12345678, 0, 0);
      end
      run_txn(1'b1, $urandom, $urandom, 16'd0, 1'b0, 1'b0, $urandom, 10, 0);
      run_txn(1'b0, $urandom, $urandom, 16'd0, 1'b1, 1'b0, $urandom, 37, 0);
      run_txn(1'b0, $urandom, $urandom, 16'd3, 1'b1, 1'b1, $urandom, 0, 40);
      run_txn(1'b0, $urandom, $urandom, 16'd1, 1'b0, 1'b1, $urandom, 0, 0);
      for (int k = 0; k < 14; k++) begin
         run_txn(1'($urandom), $urandom, $urandom, 16'($urandom_range(4, 0)),
                 1'($urandom), 1'($urandom), $urandom, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
